// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multicycle (FETCH/DECODE/EXEC/MEM/WB) control FSM for a small MIPS-like
//   datapath, with an illegal-opcode trap, a data-memory timeout trap and a
//   retired-instruction counter.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   FETCH  | request instruction; IR/PC load in the cycle instr_valid is seen
//   DECODE | capture opcode, check legality
//   EXEC   | ALU operation; branches and jumps complete here
//   MEM    | hold data-memory strobe until mem_ready or timeout
//   WB     | register-file write-back
//   TRAP   | absorbing fault state, left only through rst_n
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode                IR opcode field (stable from the cycle after ir_write)
//   instr_valid           fetch data returned
//   mem_ready             data memory access complete
//   fetch_req .. move     datapath control strobes / selects
//   ALUop                 ALU operation (zero-extended to ALUOP_W)
//   illegal_op            sticky illegal-opcode flag
//   mem_timeout           sticky memory timeout flag
//   retired               retired-instruction count (wraps)
module multicycle_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  output logic                fetch_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                regDst,
  output logic                branch,
  output logic                memRead,
  output logic                memWrite,
  output logic                memToReg,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                ALUsrc,
  output logic                regWrite,
  output logic                jump,
  output logic                byteOperations,
  output logic                move,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef struct packed {
    logic       fetch_req;
    logic       pc_write;
    logic       regDst;
    logic       branch;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic [2:0] aluop;
    logic       ALUsrc;
    logic       regWrite;
    logic       jump;
    logic       byteOperations;
    logic       move;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_SUBI = 6'b000011;
  localparam logic [5:0] OP_ANDI = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b000101;
  localparam logic [5:0] OP_SLTI = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_LB   = 6'b001001;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_SB   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b100011;
  localparam logic [5:0] OP_BNE  = 6'b100111;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111001;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  // Wait timer: loaded with MEM_TIMEOUT-1 on MEM entry, so terminal count is
  // hit in the MEM_TIMEOUT-th cycle without mem_ready.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

  function automatic logic is_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_SLTI);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic [2:0] alu_enc(input logic [5:0] op);
    logic [2:0] a;
    a = ALU_ADD;
    if (op == OP_R)                                         a = ALU_FUNCT;
    else if (op == OP_SUBI || is_branch(op))                a = ALU_SUB;
    else if (op == OP_ANDI)                                 a = ALU_AND;
    else if (op == OP_ORI)                                  a = ALU_OR;
    else if (op == OP_SLTI)                                 a = ALU_SLT;
    return a;
  endfunction

  // Moore output decode; evaluated on the next state so the outputs are
  // registered yet always match the current state.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: c.fetch_req = 1'b1;
      S_EXEC: begin
        c.aluop    = alu_enc(op);
        c.ALUsrc   = is_imm(op) || is_load(op) || is_store(op);
        c.branch   = is_branch(op);
        c.jump     = is_jump(op);
        c.pc_write = is_jump(op);
        c.regWrite = (op == OP_JAL);
        c.move     = (op == OP_JAL);
      end
      S_MEM: begin
        c.aluop          = ALU_ADD;
        c.ALUsrc         = 1'b1;
        c.memRead        = is_load(op);
        c.memWrite       = is_store(op);
        c.byteOperations = (op == OP_LB) || (op == OP_SB);
      end
      S_WB: begin
        c.aluop          = alu_enc(op);
        c.ALUsrc         = is_imm(op) || is_load(op);
        c.regWrite       = 1'b1;
        c.regDst         = (op == OP_R);
        c.memToReg       = is_load(op);
        c.byteOperations = (op == OP_LB);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t            state, state_nxt;
  logic [5:0]        op_q, op_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired_q;
  logic              illegal_q, timeout_q;
  ctrl_t             ctrl_q;
  logic              retire, set_illegal, set_timeout, op_legal;

  always_comb begin
    op_legal = ((opcode >> 6) == '0) &&
               ((opcode[5:0] == OP_R) || is_imm(opcode[5:0]) ||
                is_load(opcode[5:0]) || is_store(opcode[5:0]) ||
                is_branch(opcode[5:0]) || is_jump(opcode[5:0]));
  end

  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_FETCH: if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        op_nxt = opcode[5:0];
        if (op_legal) state_nxt = S_EXEC;
        else begin
          state_nxt   = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_load(op_q) || is_store(op_q)) state_nxt = S_MEM;
        else if (is_branch(op_q) || is_jump(op_q)) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else state_nxt = S_WB;
      end
      S_MEM: begin
        // mem_ready takes priority over a timeout in the same cycle
        if (mem_ready) begin
          if (is_load(op_q)) state_nxt = S_WB;
          else begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
        end else if (wait_cnt == '0) begin
          state_nxt   = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      ctrl_q    <= decode(S_FETCH, 6'd0);
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      ctrl_q <= decode(state_nxt, op_nxt);
      if (retire)      retired_q <= retired_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
      if (state != S_MEM && state_nxt == S_MEM) wait_cnt <= WAIT_LOAD;
      else if (state == S_MEM && !mem_ready && wait_cnt != '0)
        wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

  // IR/PC load must coincide with the instr_valid cycle, so this is the one
  // input-qualified strobe; gated by rst_n so nothing fires during reset.
  assign ir_write       = ctrl_q.fetch_req & instr_valid & rst_n;
  assign fetch_req      = ctrl_q.fetch_req;
  assign pc_write       = ctrl_q.pc_write | ir_write;
  assign regDst         = ctrl_q.regDst;
  assign branch         = ctrl_q.branch;
  assign memRead        = ctrl_q.memRead;
  assign memWrite       = ctrl_q.memWrite;
  assign memToReg       = ctrl_q.memToReg;
  assign ALUop          = ALUOP_W'(ctrl_q.aluop);
  assign ALUsrc         = ctrl_q.ALUsrc;
  assign regWrite       = ctrl_q.regWrite;
  assign jump           = ctrl_q.jump;
  assign byteOperations = ctrl_q.byteOperations;
  assign move           = ctrl_q.move;
  assign illegal_op     = illegal_q;
  assign mem_timeout    = timeout_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. A second instance with
// CNT_W = 4 shares the stimulus and is used for the counter-wrap check.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       instr_valid, mem_ready;

  logic fetch_req, ir_write, pc_write, regDst, branch, memRead, memWrite;
  logic memToReg, ALUsrc, regWrite, jump, byteOperations, move;
  logic illegal_op, mem_timeout;
  logic [2:0]  ALUop;
  logic [31:0] retired;

  logic f4, iw4, pw4, rd4, br4, mr4, mw4, mtr4, as4, rw4, j4, bo4, mv4, il4, to4;
  logic [2:0] ao4;
  logic [3:0] retired4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .fetch_req(fetch_req), .ir_write(ir_write),
    .pc_write(pc_write), .regDst(regDst), .branch(branch), .memRead(memRead),
    .memWrite(memWrite), .memToReg(memToReg), .ALUop(ALUop), .ALUsrc(ALUsrc),
    .regWrite(regWrite), .jump(jump), .byteOperations(byteOperations),
    .move(move), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .retired(retired)
  );

  multicycle_control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .fetch_req(f4), .ir_write(iw4), .pc_write(pw4),
    .regDst(rd4), .branch(br4), .memRead(mr4), .memWrite(mw4),
    .memToReg(mtr4), .ALUop(ao4), .ALUsrc(as4), .regWrite(rw4), .jump(j4),
    .byteOperations(bo4), .move(mv4), .illegal_op(il4), .mem_timeout(to4),
    .retired(retired4)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents an instruction in FETCH for one cycle; lands in DECODE.
  task automatic issue(input logic [5:0] op);
    opcode = op;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'd0; instr_valid = 1'b1; mem_ready = 1'b0;
    #12;
    n_checks++; if (ir_write !== 1'b0) begin n_fail++; $display("FAIL rst_ir_write: got %b want 0", ir_write); end
    n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL rst_retired: got %0d want 0", retired); end
    n_checks++; if ({memRead, memWrite, regWrite, illegal_op, mem_timeout} !== 5'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 00000", {memRead, memWrite, regWrite, illegal_op, mem_timeout}); end
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_req: got %b want 1", fetch_req); end
    n_checks++; if (ALUop !== 3'b000) begin n_fail++; $display("FAIL rst_aluop: got %b want 000", ALUop); end
  endtask

  task automatic test_addi();
    opcode = 6'b000010; instr_valid = 1'b1;
    #1;
    n_checks++; if ({ir_write, pc_write} !== 2'b11) begin n_fail++; $display("FAIL addi_fetch_irpc: got %b want 11", {ir_write, pc_write}); end
    step(); instr_valid = 1'b0; #1;
    n_checks++; if ({fetch_req, ir_write, pc_write} !== 3'b000) begin n_fail++; $display("FAIL addi_decode: got %b want 000", {fetch_req, ir_write, pc_write}); end
    step();
    n_checks++; if ({ALUop, ALUsrc, regWrite} !== 5'b00010) begin n_fail++; $display("FAIL addi_exec: got %b want 00010", {ALUop, ALUsrc, regWrite}); end
    step();
    n_checks++; if ({regWrite, regDst, ALUsrc, ALUop, retired[0]} !== 7'b1010000) begin n_fail++; $display("FAIL addi_wb: got %b want 1010000", {regWrite, regDst, ALUsrc, ALUop, retired[0]}); end
    step();
    n_checks++; if ({fetch_req, regWrite} !== 2'b10 || retired !== 32'd1) begin n_fail++; $display("FAIL addi_done: got fr/rw %b ret %0d want 10 ret 1", {fetch_req, regWrite}, retired); end
  endtask

  task automatic test_lb();
    issue(6'b001001);
    step(); // EXEC
    step(); // MEM1
    n_checks++; if ({memRead, memWrite, byteOperations, ALUsrc, ALUop} !== 7'b1011000) begin n_fail++; $display("FAIL lb_mem1: got %b want 1011000", {memRead, memWrite, byteOperations, ALUsrc, ALUop}); end
    step(); // MEM2
    n_checks++; if ({memRead, byteOperations} !== 2'b11) begin n_fail++; $display("FAIL lb_mem2: got %b want 11", {memRead, byteOperations}); end
    step(); // MEM3
    mem_ready = 1'b1; #1;
    n_checks++; if ({memRead, byteOperations, regWrite} !== 3'b110) begin n_fail++; $display("FAIL lb_mem3: got %b want 110", {memRead, byteOperations, regWrite}); end
    step(); mem_ready = 1'b0; // WB
    n_checks++; if ({memRead, memToReg, regWrite, byteOperations, regDst} !== 5'b01110) begin n_fail++; $display("FAIL lb_wb: got %b want 01110", {memRead, memToReg, regWrite, byteOperations, regDst}); end
    step(); // FETCH, 7th cycle elapsed
    n_checks++; if (fetch_req !== 1'b1 || retired !== 32'd2) begin n_fail++; $display("FAIL lb_done: got fr %b ret %0d want 1 ret 2", fetch_req, retired); end
  endtask

  task automatic test_r_type();
    issue(6'b000000);
    step(); // EXEC
    n_checks++; if ({ALUop, ALUsrc} !== 4'b1110) begin n_fail++; $display("FAIL r_exec: got %b want 1110", {ALUop, ALUsrc}); end
    step(); // WB
    n_checks++; if ({regWrite, regDst, memToReg} !== 3'b110) begin n_fail++; $display("FAIL r_wb: got %b want 110", {regWrite, regDst, memToReg}); end
    step();
    n_checks++; if (retired !== 32'd3) begin n_fail++; $display("FAIL r_retired: got %0d want 3", retired); end
  endtask

  task automatic test_jal_bne();
    issue(6'b111001);
    step(); // EXEC
    n_checks++; if ({jump, pc_write, regWrite, move, branch} !== 5'b11110) begin n_fail++; $display("FAIL jal_exec: got %b want 11110", {jump, pc_write, regWrite, move, branch}); end
    step();
    n_checks++; if ({fetch_req, jump, regWrite, move} !== 4'b1000 || retired !== 32'd4) begin n_fail++; $display("FAIL jal_after: got %b ret %0d want 1000 ret 4", {fetch_req, jump, regWrite, move}, retired); end
    issue(6'b100111);
    n_checks++; if (branch !== 1'b0) begin n_fail++; $display("FAIL bne_decode_branch: got %b want 0", branch); end
    step(); // EXEC
    n_checks++; if ({branch, ALUop, regWrite, jump, pc_write} !== 7'b1001000) begin n_fail++; $display("FAIL bne_exec: got %b want 1001000", {branch, ALUop, regWrite, jump, pc_write}); end
    step();
    n_checks++; if ({branch, fetch_req} !== 2'b01 || retired !== 32'd5) begin n_fail++; $display("FAIL bne_after: got %b ret %0d want 01 ret 5", {branch, fetch_req}, retired); end
  endtask

  // mem_ready arriving in the 16th MEM cycle must beat the timeout.
  task automatic test_sw_ready_at_limit();
    issue(6'b010000);
    step(); // EXEC
    step(); // MEM1
    n_checks++; if ({memWrite, memRead, byteOperations} !== 3'b100) begin n_fail++; $display("FAIL sw_mem1: got %b want 100", {memWrite, memRead, byteOperations}); end
    for (int i = 0; i < 15; i++) step(); // MEM16
    mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    n_checks++; if ({fetch_req, mem_timeout, memWrite} !== 3'b100 || retired !== 32'd6) begin n_fail++; $display("FAIL sw_limit_ready: got %b ret %0d want 100 ret 6", {fetch_req, mem_timeout, memWrite}, retired); end
  endtask

  task automatic test_reset_mid_mem();
    issue(6'b001000);
    step(); step(); // MEM1
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({memRead, fetch_req} !== 2'b01 || retired !== 32'd0) begin n_fail++; $display("FAIL midmem_reset: got %b ret %0d want 01 ret 0", {memRead, fetch_req}, retired); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) begin
      issue(6'b111000);
      step(); step();
    end
    n_checks++; if (retired4 !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d want 15", retired4); end
    issue(6'b111000);
    step(); step();
    n_checks++; if (retired4 !== 4'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", retired4); end
    n_checks++; if (retired !== 32'd16) begin n_fail++; $display("FAIL wrap_wide: got %0d want 16", retired); end
  endtask

  task automatic test_sw_timeout();
    issue(6'b010000);
    step(); step(); // MEM1
    for (int i = 0; i < 15; i++) step(); // MEM16
    n_checks++; if ({memWrite, mem_timeout} !== 2'b10) begin n_fail++; $display("FAIL to_mem16: got %b want 10", {memWrite, mem_timeout}); end
    step(); // TRAP
    n_checks++; if ({mem_timeout, fetch_req, memWrite, illegal_op} !== 4'b1000) begin n_fail++; $display("FAIL to_trap: got %b want 1000", {mem_timeout, fetch_req, memWrite, illegal_op}); end
    instr_valid = 1'b1;
    step(); step(); #1;
    n_checks++; if ({fetch_req, ir_write, pc_write} !== 3'b000 || retired !== 32'd16) begin n_fail++; $display("FAIL to_absorb: got %b ret %0d want 000 ret 16", {fetch_req, ir_write, pc_write}, retired); end
    instr_valid = 1'b0;
  endtask

  task automatic test_illegal();
    apply_reset();
    n_checks++; if ({mem_timeout, fetch_req} !== 2'b01) begin n_fail++; $display("FAIL ill_pre: got %b want 01", {mem_timeout, fetch_req}); end
    @(negedge clk);
    issue(6'b110011);
    step(); // TRAP
    n_checks++; if ({illegal_op, fetch_req, regWrite, jump} !== 4'b1000) begin n_fail++; $display("FAIL ill_trap: got %b want 1000", {illegal_op, fetch_req, regWrite, jump}); end
    step();
    n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_sticky: got %b want 1", illegal_op); end
    apply_reset();
    n_checks++; if ({illegal_op, fetch_req} !== 2'b01) begin n_fail++; $display("FAIL ill_cleared: got %b want 01", {illegal_op, fetch_req}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lb();
    test_r_type();
    test_jal_bne();
    test_sw_ready_at_limit();
    test_reset_mid_mem();
    test_wrap();
    test_sw_timeout();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 6, opcode field width; only the low 6 bits are decoded and all higher bits SHALL be zero for a legal opcode.
REQ-002 The block SHALL have parameter ALUOP_W, default 3 (minimum 3), ALUop width; encodings are zero-extended.
REQ-003 The block SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of MEM-state cycles before a trap.
REQ-004 The block SHALL have parameter CNT_W, default 32, the retired-instruction counter width.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset; ports clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset).
REQ-006 The block SHALL have these ports, beyond clk and rst_n:
- opcode (in, OPCODE_W): IR opcode field, stable from the cycle after ir_write.
- instr_valid (in, 1): fetch data returned.
- mem_ready (in, 1): data memory access complete.
- fetch_req (out, 1): instruction fetch request.
- ir_write (out, 1): load IR.
- pc_write (out, 1): unconditional PC update.
- regDst (out, 1): rd/rt select.
- branch (out, 1): conditional PC update, qualified by the datapath.
- memRead, memWrite (out, 1 each): data memory strobes.
- memToReg (out, 1): write-back source is memory.
- ALUop (out, ALUOP_W): ALU operation.
- ALUsrc (out, 1): immediate operand.
- regWrite (out, 1): register file write.
- jump (out, 1): jump target select.
- byteOperations (out, 1): byte-wide access.
- move (out, 1): write PC+4 to $31.
- illegal_op (out, 1): sticky trap flag.
- mem_timeout (out, 1): sticky timeout flag.
- retired (out, CNT_W): retired-instruction count.

Function
REQ-007 The block SHALL implement a registered Moore FSM with states FETCH, DECODE, EXEC, MEM, WB and TRAP; all outputs SHALL be decoded from state plus the registered opcode only.
REQ-008 The block SHALL decode these legal opcodes:
- R = 000000
- addi = 000010, subi = 000011, andi = 000100, ori = 000101, slti = 000111
- lw = 001000, lb = 001001, sw = 010000, sb = 010001
- beq = 100011, bne = 100111
- j = 111000, jal = 111001
REQ-009 The block SHALL use these ALUop encodings: ADD = 000 (addi, lw, lb, sw, sb), SUB = 001 (subi, beq, bne), AND = 010, OR = 011, SLT = 100, FUNCT = 111 (R); ALUop SHALL be 000 in states FETCH and TRAP.
REQ-010 In FETCH, fetch_req SHALL be 1. When instr_valid = 1, ir_write and pc_write SHALL be 1 for that cycle and the next state SHALL be DECODE; otherwise the FSM SHALL remain in FETCH.
REQ-011 In DECODE, the block SHALL register opcode. An illegal opcode SHALL set the next state to TRAP; any legal opcode SHALL set it to EXEC.
REQ-012 EXEC SHALL assert ALUop per REQ-009. ALUsrc SHALL be 1 for immediate, load and store opcodes. Next state:
- R and immediate opcodes: WB.
- loads and stores: MEM.
- beq/bne: branch = 1 for exactly one cycle, then FETCH.
- j: jump = 1 and pc_write = 1, then FETCH.
- jal: jump = 1, pc_write = 1, regWrite = 1 and move = 1 in the same cycle, then FETCH.
REQ-013 In MEM, memRead (loads) or memWrite (stores) SHALL be held, together with ALUop = ADD and ALUsrc = 1, until mem_ready = 1. byteOperations SHALL be 1 for lb and sb.
- On mem_ready: a load SHALL go to WB; a store SHALL go to FETCH.
REQ-014 In MEM, a wait counter SHALL count cycles without mem_ready. On reaching MEM_TIMEOUT, mem_timeout SHALL be set and the next state SHALL be TRAP. mem_ready arriving in the same cycle as the limit SHALL win, and no trap SHALL be raised.
REQ-015 In WB, regWrite SHALL be 1 for exactly one cycle. regDst SHALL be 1 only for R. memToReg SHALL be 1 only for loads, and byteOperations SHALL be 1 for lb. The next state SHALL be FETCH.
REQ-016 The block SHALL increment retired by 1 on the cycle an instruction leaves toward FETCH (EXEC for branches and jumps, MEM for stores, WB otherwise); the counter SHALL wrap modulo 2^CNT_W.
REQ-017 TRAP SHALL be absorbing: illegal_op is set on entry from DECODE, and in TRAP all strobes (fetch_req, ir_write, pc_write, branch, memRead, memWrite, regWrite, jump, move) SHALL be 0.
REQ-018 Every strobe not named for the current state/opcode SHALL be 0; memRead and memWrite SHALL never be 1 simultaneously.

Reset
REQ-019 When rst_n = 0, the block SHALL asynchronously set the state to FETCH and clear the registered opcode, wait counter, retired, illegal_op, mem_timeout and every output to 0, except fetch_req, which SHALL be 1 once rst_n is released.
REQ-020 Reset asserted mid-MEM SHALL drop memRead/memWrite in the same instant, without waiting for a clock edge.

Verification
REQ-021 addi with instr_valid in the first FETCH cycle -> 4 cycles (FETCH, DECODE, EXEC, WB), WB: regWrite = 1, regDst = 0, ALUsrc = 1, ALUop = 000; retired 0 -> 1.
REQ-022 lb with mem_ready on the 3rd MEM cycle -> memRead and byteOperations held for 3 cycles, then WB with memToReg = 1; 7 cycles in total.
REQ-023 sw with mem_ready held at 0 -> after 16 MEM cycles, mem_timeout = 1 and state TRAP; fetch_req remains 0 until reset.
REQ-024 opcode 110011 -> TRAP after DECODE, illegal_op = 1; a following rst_n pulse clears it and fetch_req returns to 1.
REQ-025 jal -> a single EXEC cycle with jump = pc_write = regWrite = move = 1; bne -> branch = 1 for exactly one cycle with ALUop = 001 and no regWrite.
REQ-026 With CNT_W = 4, 16 retired instructions -> retired wraps from 15 to 0.
